// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage with ALU, operand forwarding and iterative multiplier.
// Define EX_FWD_EN to build the MEM/WB forwarding muxes; otherwise operands come straight from ID.
module ex_stage_pipe #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_inA,
  input  logic [DW-1:0] id_inB,
  input  logic          id_wreg,
  input  logic          id_m2reg,
  input  logic          id_wmem,
  input  logic          id_branch,
  input  logic [3:0]    id_aluc,
  input  logic          id_aluimm,
  input  logic          id_shift,
  input  logic          id_mul,
  input  logic          id_regrt,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_pc4,
  input  logic [1:0]    fwd_a_sel,
  input  logic [1:0]    fwd_b_sel,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic [DW-1:0] wb_fwd_data,
  input  logic          ex_stall_in,
  input  logic          flush,
  input  logic [TW-1:0] ID_ins_type,
  input  logic [TW-1:0] ID_ins_number,
  output logic          ex_busy,
  output logic          ex_valid,
  output logic          ex_wreg,
  output logic          ex_m2reg,
  output logic          ex_wmem,
  output logic          ex_branch,
  output logic [DW-1:0] ex_aluR,
  output logic [DW-1:0] ex_hi,
  output logic [DW-1:0] ex_inB,
  output logic [RW-1:0] ex_destR,
  output logic [DW-1:0] ex_pc,
  output logic [TW-1:0] EXE_ins_type,
  output logic [TW-1:0] EXE_ins_number
);

  localparam int SW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   cnt;
  logic [DW-1:0]   mcand;
  logic [DW-1:0]   mplier;
  logic [2*DW-1:0] acc;
  logic [2*DW-1:0] mcand_x;

  logic [DW-1:0] fa;
  logic [DW-1:0] fb;
  logic [DW-1:0] shamt;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic [DW-1:0] alu_r;
  logic [DW-1:0] res;
  logic [SW-1:0] sh;
  logic          zero;
  logic          done;
  logic          mul_run;
  logic          mul_start;
  logic          br_take;
  logic [RW-1:0] dest;

`ifdef EX_FWD_EN
  always_comb begin
    fa = id_inA;
    unique case (fwd_a_sel)
      2'b01:   fa = mem_fwd_data;
      2'b10:   fa = wb_fwd_data;
      default: fa = id_inA;
    endcase
  end

  always_comb begin
    fb = id_inB;
    unique case (fwd_b_sel)
      2'b01:   fb = mem_fwd_data;
      2'b10:   fb = wb_fwd_data;
      default: fb = id_inB;
    endcase
  end
`else
  logic fwd_unused;
  assign fa = id_inA;
  assign fb = id_inB;
  assign fwd_unused = ^{fwd_a_sel, fwd_b_sel,
                        mem_fwd_data, wb_fwd_data};
`endif

  assign shamt = (id_imm >> 6) & DW'(31);
  assign a_in  = id_shift ? shamt : fa;
  assign b_in  = id_aluimm ? id_imm : fb;
  assign sh    = a_in[SW-1:0];

  always_comb begin
    alu_r = '0;
    unique casez (id_aluc)
      4'b?000: alu_r = a_in + b_in;
      4'b?100: alu_r = a_in - b_in;
      4'b?001: alu_r = a_in & b_in;
      4'b?101: alu_r = a_in | b_in;
      4'b?010: alu_r = a_in ^ b_in;
      4'b?110: alu_r = {b_in[DW/2-1:0], {(DW/2){1'b0}}};
      4'b0011: alu_r = b_in << sh;
      4'b0111: alu_r = b_in >> sh;
      4'b1111: alu_r = DW'($signed(b_in) >>> sh);
      default: alu_r = '0;
    endcase
  end

  assign zero      = (alu_r == '0);
  assign done      = (state == DONE);
  assign mul_run   = (state == MUL);
  assign mul_start = (state == IDLE) & id_valid & id_mul;
  assign res       = done ? acc[DW-1:0] : alu_r;
  assign br_take   = id_branch & zero & id_valid & ~done;
  assign dest      = id_regrt ? id_rt : id_rd;
  assign mcand_x   = {{DW{1'b0}}, mcand};

  assign ex_busy = ~rst & ((mul_start & ~flush) | mul_run);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      ex_valid       <= 1'b0;
      ex_wreg        <= 1'b0;
      ex_m2reg       <= 1'b0;
      ex_wmem        <= 1'b0;
      ex_branch      <= 1'b0;
      ex_aluR        <= '0;
      ex_hi          <= '0;
      ex_inB         <= '0;
      ex_destR       <= '0;
      ex_pc          <= '0;
      EXE_ins_type   <= '0;
      EXE_ins_number <= '0;
    end else if (flush) begin
      state          <= IDLE;
      ex_valid       <= 1'b0;
      ex_wreg        <= 1'b0;
      ex_m2reg       <= 1'b0;
      ex_wmem        <= 1'b0;
      ex_branch      <= 1'b0;
      EXE_ins_type   <= '0;
      EXE_ins_number <= '0;
    end else if (!ex_stall_in) begin
      unique case (1'b1)
        mul_run: begin
          if (mplier[0]) acc <= acc + (mcand_x << cnt);
          mplier         <= mplier >> 1;
          cnt            <= cnt + 1'b1;
          if (cnt == SW'(DW - 1)) state <= DONE;
          ex_valid       <= 1'b0;
          ex_wreg        <= 1'b0;
          ex_m2reg       <= 1'b0;
          ex_wmem        <= 1'b0;
          ex_branch      <= 1'b0;
          EXE_ins_type   <= '0;
          EXE_ins_number <= '0;
        end
        mul_start: begin
          mcand          <= fa;
          mplier         <= fb;
          acc            <= '0;
          cnt            <= '0;
          state          <= MUL;
          ex_valid       <= 1'b0;
          ex_wreg        <= 1'b0;
          ex_m2reg       <= 1'b0;
          ex_wmem        <= 1'b0;
          ex_branch      <= 1'b0;
          EXE_ins_type   <= '0;
          EXE_ins_number <= '0;
        end
        default: begin
          // IDLE single-cycle op, or DONE retiring the held MUL
          ex_valid       <= id_valid;
          ex_wreg        <= id_wreg & id_valid;
          ex_m2reg       <= id_m2reg & id_valid;
          ex_wmem        <= id_wmem & id_valid;
          ex_branch      <= br_take;
          ex_aluR        <= res;
          ex_inB         <= fb;
          ex_destR       <= dest;
          ex_pc          <= id_pc4 + (id_imm << 2);
          EXE_ins_type   <= ID_ins_type;
          EXE_ins_number <= ID_ins_number;
          if (done) ex_hi <= acc[2*DW-1:DW];
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed and random checks of ex_stage_pipe against a behavioural model.
// Forwarding expectations follow EX_FWD_EN when the bench is built with it.
module tb_ex_stage_pipe;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TW = 4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_LUI = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1111;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [DW-1:0] id_imm, id_inA, id_inB, id_pc4;
  logic          id_wreg, id_m2reg, id_wmem, id_branch;
  logic [3:0]    id_aluc;
  logic          id_aluimm, id_shift, id_mul, id_regrt;
  logic [RW-1:0] id_rt, id_rd;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [DW-1:0] mem_fwd_data, wb_fwd_data;
  logic          ex_stall_in, flush;
  logic [TW-1:0] ID_ins_type, ID_ins_number;
  logic          ex_busy, ex_valid;
  logic          ex_wreg, ex_m2reg, ex_wmem, ex_branch;
  logic [DW-1:0] ex_aluR, ex_hi, ex_inB, ex_pc;
  logic [RW-1:0] ex_destR;
  logic [TW-1:0] EXE_ins_type, EXE_ins_number;

  ex_stage_pipe #(.DW(DW), .RW(RW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_imm(id_imm), .id_inA(id_inA), .id_inB(id_inB),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wmem(id_wmem), .id_branch(id_branch),
    .id_aluc(id_aluc), .id_aluimm(id_aluimm),
    .id_shift(id_shift), .id_mul(id_mul),
    .id_regrt(id_regrt), .id_rt(id_rt), .id_rd(id_rd),
    .id_pc4(id_pc4), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_data(wb_fwd_data), .ex_stall_in(ex_stall_in),
    .flush(flush), .ID_ins_type(ID_ins_type),
    .ID_ins_number(ID_ins_number), .ex_busy(ex_busy),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg),
    .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_branch(ex_branch), .ex_aluR(ex_aluR),
    .ex_hi(ex_hi), .ex_inB(ex_inB), .ex_destR(ex_destR),
    .ex_pc(ex_pc), .EXE_ins_type(EXE_ins_type),
    .EXE_ins_number(EXE_ins_number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_hi;
  logic [DW-1:0] last_r;
  logic [3:0]    ops [9];

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int s;
    s = int'(a % 32);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_LUI:  return b * 32'h10000;
      OP_SLL:  return b << s;
      OP_SRL:  return b >> s;
      OP_SRA:  return 32'($signed(b) >>> s);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel,
                                      input logic [31:0] rv,
                                      input logic [31:0] m,
                                      input logic [31:0] w);
`ifdef EX_FWD_EN
    if (sel == 2'b01) return m;
    if (sel == 2'b10) return w;
`endif
    return rv;
  endfunction

  task automatic clear_in();
    id_valid = 0; id_imm = 0; id_inA = 0; id_inB = 0;
    id_wreg = 0; id_m2reg = 0; id_wmem = 0; id_branch = 0;
    id_aluc = 0; id_aluimm = 0; id_shift = 0; id_mul = 0;
    id_regrt = 0; id_rt = 0; id_rd = 0; id_pc4 = 0;
    fwd_a_sel = 0; fwd_b_sel = 0;
    mem_fwd_data = 0; wb_fwd_data = 0;
    ex_stall_in = 0; flush = 0;
    ID_ins_type = 0; ID_ins_number = 0;
  endtask

  // Expected EX/MEM contents for the single-cycle instruction now on the ID inputs
  task automatic do_alu(input string tag);
    logic [31:0] fa, fb, a, b, r;
    fa = fwd(fwd_a_sel, id_inA, mem_fwd_data, wb_fwd_data);
    fb = fwd(fwd_b_sel, id_inB, mem_fwd_data, wb_fwd_data);
    a  = id_shift ? ((id_imm / 64) % 32) : fa;
    b  = id_aluimm ? id_imm : fb;
    r  = ref_alu(id_aluc, a, b);
    last_r = r;
    @(posedge clk); #1;
    check({tag, "_aluR"}, ex_aluR, r);
    check({tag, "_valid"}, ex_valid, id_valid);
    check({tag, "_wreg"}, ex_wreg, id_wreg && id_valid);
    check({tag, "_m2reg"}, ex_m2reg, id_m2reg && id_valid);
    check({tag, "_wmem"}, ex_wmem, id_wmem && id_valid);
    check({tag, "_branch"}, ex_branch,
          id_branch && (r == 0) && id_valid);
    check({tag, "_dest"}, ex_destR, id_regrt ? id_rt : id_rd);
    check({tag, "_pc"}, ex_pc, 32'(id_pc4 + id_imm * 4));
    check({tag, "_inB"}, ex_inB, fb);
    check({tag, "_hi"}, ex_hi, exp_hi);
    check({tag, "_tag"}, {EXE_ins_type, EXE_ins_number},
          {ID_ins_type, ID_ins_number});
  endtask

  task automatic do_mul(input logic [31:0] a,
                        input logic [31:0] b,
                        input string tag,
                        input bit stall_done);
    logic [63:0] prod;
    logic [4:0]  rd;
    int n;
    rd = 5'($urandom_range(31));
    id_valid = 1; id_mul = 1; id_inA = a; id_inB = b;
    fwd_a_sel = 0; fwd_b_sel = 0; id_aluimm = 0;
    id_shift = 0; id_wreg = 1; id_regrt = 0;
    id_rd = rd; id_branch = 1; id_aluc = OP_SUB;
    #1;
    n = 0;
    while (ex_busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_busy_cycles"}, n, 33);
    check({tag, "_bubble"}, ex_valid, 0);
    check({tag, "_hi_hold"}, ex_hi, exp_hi);
    if (stall_done) begin
      ex_stall_in = 1;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_stall_valid"}, ex_valid, 0);
      check({tag, "_stall_busy"}, ex_busy, 0);
      check({tag, "_stall_hi"}, ex_hi, exp_hi);
      ex_stall_in = 0;
    end
    @(posedge clk); #1;
    prod = 64'(a) * 64'(b);
    exp_hi = prod[63:32];
    check({tag, "_lo"}, ex_aluR, prod[31:0]);
    check({tag, "_hi"}, ex_hi, prod[63:32]);
    check({tag, "_valid"}, ex_valid, 1);
    check({tag, "_wreg"}, ex_wreg, 1);
    check({tag, "_dest"}, ex_destR, rd);
    check({tag, "_branch"}, ex_branch, 0);
    clear_in();
  endtask

  task automatic rand_alu(input string tag);
    id_valid = ($urandom_range(7) != 0);
    id_mul = 0;
    id_aluc = ops[$urandom_range(8)];
    id_inA = $urandom; id_inB = $urandom;
    id_imm = $urandom; id_pc4 = $urandom;
    if ($urandom_range(3) == 0) id_inB = id_inA;
    id_wreg = 1'($urandom); id_m2reg = 1'($urandom);
    id_wmem = 1'($urandom); id_branch = 1'($urandom);
    id_aluimm = ($urandom_range(3) == 0);
    id_shift = ($urandom_range(3) == 0);
    id_regrt = 1'($urandom);
    id_rt = 5'($urandom); id_rd = 5'($urandom);
    fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom);
    mem_fwd_data = $urandom; wb_fwd_data = $urandom;
    ID_ins_type = 4'($urandom); ID_ins_number = 4'($urandom);
    do_alu(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_LUI, OP_SLL, OP_SRL, OP_SRA};
    exp_hi = 0;
    rst = 1;
    clear_in();
    #2;
    check("rst_valid", ex_valid, 0);
    check("rst_aluR", ex_aluR, 0);
    check("rst_hi", ex_hi, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_busy", ex_busy, 0);
    @(negedge clk);
    rst = 0;

    // ADD 5 + 7 into r3
    id_valid = 1; id_inA = 5; id_inB = 7;
    id_aluc = OP_ADD; id_rd = 3; id_wreg = 1;
    do_alu("add");
    check("add_lit", ex_aluR, 12);
    check("add_dest_lit", ex_destR, 3);

    // BEQ taken and not taken
    clear_in();
    id_valid = 1; id_inA = 9; id_inB = 9; id_aluc = OP_SUB;
    id_branch = 1; id_pc4 = 32'h100; id_imm = 4;
    do_alu("beq_t");
    check("beq_t_lit", ex_branch, 1);
    check("beq_pc_lit", ex_pc, 32'h110);
    id_inB = 8;
    do_alu("beq_nt");
    check("beq_nt_lit", ex_branch, 0);

    clear_in();
    do_mul(7, 9, "mul79", 0);
    check("mul79_lit", {ex_hi, ex_aluR}, 64'd63);
    do_mul(32'hFFFF_FFFF, 2, "mulff", 0);
    check("mulff_lit", {ex_hi, ex_aluR}, 64'h1_FFFF_FFFE);

    // Flush at multiply cycle 10
    id_valid = 1; id_mul = 1; id_inA = 12345; id_inB = 678;
    #1;
    repeat (10) @(posedge clk);
    #1;
    check("flush_busy_pre", ex_busy, 1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0; id_valid = 0; id_mul = 0;
    #1;
    check("flush_busy", ex_busy, 0);
    check("flush_valid", ex_valid, 0);
    check("flush_hi", ex_hi, exp_hi);
    clear_in();
    id_valid = 1; id_inA = 40; id_inB = 2;
    id_aluc = OP_ADD; id_wreg = 1; id_rd = 7;
    do_alu("post_flush");

    // Downstream stall freezes EX/MEM
    id_inA = 100; id_inB = 23;
    do_alu("pre_stall");
    ex_stall_in = 1;
    id_inA = 1; id_inB = 1; id_rd = 9;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_aluR", ex_aluR, last_r);
      check("stall_valid", ex_valid, 1);
      check("stall_dest", ex_destR, 7);
    end
    ex_stall_in = 0;
    do_alu("post_stall");

    do_mul(32'h1234_5678, 32'h9ABC_DEF0, "mul_stall", 1);

    // Flush beats stall
    id_valid = 1; id_inA = 3; id_inB = 4;
    id_aluc = OP_ADD; id_wreg = 1;
    do_alu("pre_fs");
    flush = 1; ex_stall_in = 1;
    @(posedge clk); #1;
    check("fs_valid", ex_valid, 0);
    check("fs_wreg", ex_wreg, 0);
    clear_in();

    // Reset in the middle of a multiply
    id_valid = 1; id_mul = 1; id_inA = 77; id_inB = 88;
    #1;
    repeat (5) @(posedge clk);
    #1;
    id_valid = 0; id_mul = 0;
    rst = 1;
    #1;
    exp_hi = 0;
    check("rstmul_busy", ex_busy, 0);
    check("rstmul_valid", ex_valid, 0);
    check("rstmul_aluR", ex_aluR, 0);
    check("rstmul_hi", ex_hi, 0);
    @(negedge clk);
    rst = 0;
    clear_in();
    id_valid = 1; id_inA = 6; id_inB = 6; id_aluc = OP_XOR;
    do_alu("post_rst");

    // Forwarding selects
    clear_in();
    id_valid = 1; id_aluc = OP_ADD; id_inA = 20; id_inB = 1;
    fwd_a_sel = 2'b01; mem_fwd_data = 100;
    do_alu("fwd_a");
`ifdef EX_FWD_EN
    check("fwd_a_lit", ex_aluR, 101);
`else
    check("fwd_a_lit", ex_aluR, 21);
`endif
    fwd_a_sel = 0; fwd_b_sel = 2'b10; wb_fwd_data = 50;
    do_alu("fwd_b");
`ifdef EX_FWD_EN
    check("fwd_b_lit", ex_inB, 50);
`else
    check("fwd_b_lit", ex_inB, 1);
`endif

    // Random mix of ALU ops and occasional multiplies
    clear_in();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(11) == 0)
        do_mul($urandom, $urandom, "rmul", 1'($urandom));
      else
        rand_alu("ralu");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
